// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with write-first bypass,
// per-register pending-write scoreboard and a sequential bulk-clear engine.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
module reg_file_sb #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    read_reg1,
  input  logic [AW-1:0]    read_reg2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2,
  output logic             busy1,
  output logic             busy2,
  input  logic [AW-1:0]    write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic             RegWrite,
  input  logic [AW-1:0]    reserve_reg,
  input  logic             reserve_en,
  input  logic             clear_req,
  output logic             clear_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [AW-1:0]     idx_q;
  logic [AW-1:0]     idx_d;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  sb;

  logic              idle;
  logic              wr_en;
  logic              rsv_en;
  logic              bypass_en;

  // Writes and reserves are only honoured in IDLE; bypass is held off in reset.
  assign idle = (state_q == IDLE);
`ifdef ZERO_REG_EN
  assign wr_en  = RegWrite   && idle && (write_reg   != '0);
  assign rsv_en = reserve_en && idle && (reserve_reg != '0);
`else
  assign wr_en  = RegWrite   && idle;
  assign rsv_en = reserve_en && idle;
`endif
  assign bypass_en  = wr_en && !rst;
  assign clear_busy = (state_q == CLEAR);

  // Clear FSM state and index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Clear FSM next-state: walk idx from 0 to DEPTH-1, then return to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage and scoreboard update; a same-cycle reserve overrides the write's clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      sb <= '0;
    end else if (state_q == CLEAR) begin
      mem[idx_q] <= '0;
      sb[idx_q]  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[write_reg] <= write_data;
        sb[write_reg]  <= 1'b0;
      end
      if (rsv_en) begin
        sb[reserve_reg] <= 1'b1;
      end
    end
  end

  // Read port 1: stored value, write-first bypass, busy from the held scoreboard.
  always_comb begin
    read_data1 = mem[read_reg1];
    busy1      = sb[read_reg1];
    if (bypass_en && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end
`ifdef ZERO_REG_EN
    if (read_reg1 == '0) begin
      read_data1 = '0;
      busy1      = 1'b0;
    end
`endif
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    read_data2 = mem[read_reg2];
    busy2      = sb[read_reg2];
    if (bypass_en && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end
`ifdef ZERO_REG_EN
    if (read_reg2 == '0) begin
      read_data2 = '0;
      busy2      = 1'b0;
    end
`endif
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the fixed 32x64 register file. It adds three things:
- a write-to-read bypass,
- a per-register pending-write scoreboard for hazard detection,
- a sequential bulk-clear engine.

The block sits in the decode stage of the datapath. It feeds the ALU operand muxes and the branch comparator, and it is written from writeback.

## Interface
Parameters:
- WIDTH, 64, data width of each register
- DEPTH, 32, number of registers; must be a power of two, at least 2
- AW, 5, address width; must equal log2(DEPTH)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- read_reg1  in  AW  read port 1 address
- read_reg2  in  AW  read port 2 address
- read_data1  out  WIDTH  read port 1 data (combinational)
- read_data2  out  WIDTH  read port 2 data (combinational)
- busy1  out  1  scoreboard bit of read_reg1
- busy2  out  1  scoreboard bit of read_reg2
- write_reg  in  AW  writeback address
- write_data  in  WIDTH  writeback data
- RegWrite  in  1  writeback enable
- reserve_reg  in  AW  address of an issued instruction's destination
- reserve_en  in  1  set the scoreboard bit of reserve_reg
- clear_req  in  1  start a bulk clear (single-cycle pulse or level)
- clear_busy  out  1  bulk clear in progress

## Operation
- **Storage:** DEPTH x WIDTH flops plus DEPTH scoreboard bits sb[].
- **Write:** when RegWrite=1 and the block is in IDLE, mem[write_reg] <= write_data and sb[write_reg] <= 0 on the clock edge.
- **Reserve:**
  - When reserve_en=1 and the block is in IDLE, sb[reserve_reg] <= 1.
  - If the reserve and a write target the same register in the same cycle, the reserve wins and sb stays 1 (a newer producer has been issued).
- **Read:**
  - read_dataN = write_data when RegWrite=1, the block is IDLE and write_reg==read_regN (write-first bypass).
  - Otherwise read_dataN = mem[read_regN].
- **Busy:**
  - busyN = sb[read_regN] as held in the register, before any same-cycle update.
  - A bypassed read still reports busyN as it stood before the write clears the bit.
- **Clear FSM:**
  - States: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req=1; the index counter idx is set to 0.
  - In CLEAR, each cycle: mem[idx] <= 0, sb[idx] <= 0, idx <= idx+1.
  - CLEAR -> IDLE on the cycle idx==DEPTH-1 is cleared.
  - clear_req is ignored while in CLEAR; a held level restarts the clear only after the FSM returns to IDLE.
  - In CLEAR, RegWrite and reserve_en are ignored (writes are dropped) and the bypass is disabled.
  - Reads in CLEAR return current contents: entries below idx are already 0, the rest keep their old values.
  - clear_busy = (state==CLEAR).
- **Reset (rst=1, asynchronous):**
  - All mem entries are set to 0, all sb bits to 0, state to IDLE and idx to 0.
  - Resulting outputs: read_data1/2 = 0 (the bypass is held off while rst=1), busy1/2 = 0, clear_busy = 0.
  - Reset during CLEAR aborts the clear immediately.
- **Arithmetic:** idx is AW bits wide; wrap from DEPTH-1 is not used because the FSM exits first.

## Timing
- Read and bypass paths are combinational: 0 cycles.
- A write or reserve is visible through mem/busy on the cycle after the edge.
- Bulk clear:
  - clear_req sampled at edge T; clear_busy=1 from T through T+DEPTH.
  - Register k is zeroed at edge T+1+k.
  - clear_busy=0 and writes are accepted again from the cycle after edge T+DEPTH.
  - Total: DEPTH cycles busy.
- Both read ports may address the same register, the write target, or the reserve target in the same cycle without conflict.

## Configuration
- **ZERO_REG_EN defined:** register 0 is hardwired to zero.
  - read_dataN = 0 and busyN = 0 whenever read_regN == 0.
  - Writes and reserves to address 0 are discarded.
  - There is no bypass for address 0.
- **ZERO_REG_EN not defined:** register 0 is an ordinary register, identical to all others.

## Test plan
- **Reset then read all:** reset, then read addresses 0..DEPTH-1 -> every read_data=0, busy=0, clear_busy=0.
- **Write, read, bypass:**
  - Write 0xDEAD_BEEF_0000_0001 to r5; next cycle read r5 on both ports -> both return that value.
  - Same-cycle write of 0x1234 to r7 with read_reg1=7 -> read_data1=0x1234 in that cycle, while r7 itself updates only at the edge.
- **Scoreboard:**
  - Reserve r9 -> busy1=1 next cycle with read_reg1=9.
  - Write r9 -> busy1=0 the following cycle.
  - Reserve r9 and write r9 in the same cycle -> busy stays 1 and the data still updates.
- **Bulk clear:**
  - Fill r1..r31 with nonzero values, pulse clear_req -> clear_busy high for exactly 32 cycles, and r3 reads 0 from the cycle after edge T+4.
  - A RegWrite to r10 during the clear is dropped: r10 reads 0 after the clear.
  - A clear_req during the clear is ignored.
- **Reset mid-clear:** assert rst at clear cycle 10 -> clear_busy drops immediately, all registers read 0, the FSM is in IDLE, and a write on the first cycle after reset deasserts is accepted.
- **ZERO_REG_EN built:** write 0xFF to r0 and reserve r0 -> read_data=0 and busy=0. **ZERO_REG_EN not built:** the same stimulus -> read_data=0xFF; busy=1 after the reserve alone.
